octave_scheduler: RTL and testbench

- Sequences the shared image_half_full resizer across successive downsampling passes to build an octave pyramid in one pyramid BRAM.
- Octave 0 is the received image; each pass k reads octave k and writes octave k+1 at a packed base address.
- Arbitrates the pyramid BRAM read port between the resizer and the UART image sender (send_img).
- Sits in top_level between the UART receive logic, image_half_full and send_img.

---
 rtl/octave_pkg.sv | 28 ++
 rtl/octave_rd_arbiter.sv | 21 ++
 rtl/octave_scheduler.sv | 172 +++++++++++++++++
 tb/tb_octave_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/octave_pkg.sv
// rtl/octave_pkg.sv - shared state encoding and pyramid address helpers for octave_scheduler
package octave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } octave_state_t;

    function automatic int unsigned octave_pixels(input int unsigned k, input int unsigned w,
                                                  input int unsigned h);
        return (w >> k) * (h >> k);
    endfunction

    // Octaves are packed back to back, so base(k) is the pixel count of all smaller k.
    function automatic int unsigned octave_base(input int unsigned k, input int unsigned w,
                                                input int unsigned h);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < k; i++) begin
            sum = sum + octave_pixels(i, w, h);
        end
        return sum;
    endfunction

endpackage

// File: rtl/octave_rd_arbiter.sv
// rtl/octave_rd_arbiter.sv - pyramid BRAM read-port grant for the UART image sender
module octave_rd_arbiter (
    input  logic clk_in,
    input  logic rst_in,
    input  logic tx_req_in,
    input  logic grant_allowed,
    output logic tx_grant_out
);

    // Release is unconditional on a dropped request; new grants only when the scheduler is idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_grant_out <= 1'b0;
        end else if (!tx_req_in) begin
            tx_grant_out <= 1'b0;
        end else if (grant_allowed) begin
            tx_grant_out <= 1'b1;
        end
    end

endmodule

// File: rtl/octave_scheduler.sv
// rtl/octave_scheduler.sv - sequences image_half_full passes into a packed octave pyramid; OCTAVE_SCHED_TIMEOUT_EN adds a WAIT watchdog
module octave_scheduler
    import octave_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned HEIGHT         = 64,
    parameter int unsigned NUM_OCTAVES    = 3,
    parameter int unsigned ADDR_W         = $clog2(2 * WIDTH * HEIGHT),
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_in,
    output logic                           resize_start_out,
    input  logic                           resize_done_in,
    output logic [ADDR_W-1:0]              src_base_out,
    output logic [ADDR_W-1:0]              dst_base_out,
    output logic [15:0]                    src_width_out,
    output logic [15:0]                    src_height_out,
    output logic [$clog2(NUM_OCTAVES)-1:0] pass_out,
    output logic                           rd_sel_out,
    input  logic                           tx_req_in,
    output logic                           tx_grant_out,
    output logic                           busy_out,
    output logic                           pyramid_done_out,
    output logic                           error_out,
    output logic                           start_dropped_out
);

    localparam int unsigned PASS_W = $clog2(NUM_OCTAVES);
    localparam int unsigned IDX_W  = $clog2(NUM_OCTAVES + 1);

    octave_state_t state_q, state_d;

    logic [PASS_W-1:0] pass_q;
    logic [ADDR_W-1:0] src_base_q, dst_base_q;
    logic [15:0]       src_width_q, src_height_q;
    logic              pyramid_done_q, start_dropped_q;
    logic              idle_like, start_accept, last_pass, done_hit, advance, finish;
    logic              timeout_hit;

    logic [ADDR_W-1:0] base_tbl [2**IDX_W];

    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_base
        assign base_tbl[g] = ADDR_W'(octave_base(g, WIDTH, HEIGHT));
    end

    assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign start_accept = start_in && idle_like && !tx_grant_out;
    assign last_pass    = (pass_q == PASS_W'(NUM_OCTAVES - 2));
    assign done_hit     = (state_q == ST_WAIT) && resize_done_in;
    assign advance      = done_hit && !last_pass;
    assign finish       = done_hit && last_pass;

`ifdef OCTAVE_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             error_q;

    assign timeout_hit = (state_q == ST_WAIT) && !resize_done_in
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if (state_q == ST_LAUNCH) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
            if (start_accept) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_out = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign error_out      = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        resize_start_out = 1'b0;
        busy_out         = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_accept) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                resize_start_out = 1'b1;
                busy_out         = 1'b1;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                busy_out = 1'b1;
                if (finish) begin
                    state_d = ST_DONE;
                end else if (advance) begin
                    state_d = ST_LAUNCH;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pass descriptors only move on an accepted start or a completed pass, so they hold in DONE/ERROR.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pass_q          <= '0;
            src_base_q      <= '0;
            dst_base_q      <= '0;
            src_width_q     <= '0;
            src_height_q    <= '0;
            pyramid_done_q  <= 1'b0;
            start_dropped_q <= 1'b0;
        end else begin
            pyramid_done_q  <= finish;
            start_dropped_q <= start_in && !start_accept;
            if (start_accept) begin
                pass_q       <= '0;
                src_base_q   <= base_tbl[0];
                dst_base_q   <= base_tbl[1];
                src_width_q  <= 16'(WIDTH);
                src_height_q <= 16'(HEIGHT);
            end else if (advance) begin
                pass_q       <= pass_q + PASS_W'(1);
                src_base_q   <= dst_base_q;
                dst_base_q   <= base_tbl[IDX_W'(pass_q) + IDX_W'(2)];
                src_width_q  <= src_width_q >> 1;
                src_height_q <= src_height_q >> 1;
            end
        end
    end

    octave_rd_arbiter u_rd_arbiter (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tx_req_in     (tx_req_in),
        .grant_allowed (idle_like && !start_accept),
        .tx_grant_out  (tx_grant_out)
    );

    assign rd_sel_out        = tx_grant_out;
    assign pass_out          = pass_q;
    assign src_base_out      = src_base_q;
    assign dst_base_out      = dst_base_q;
    assign src_width_out     = src_width_q;
    assign src_height_out    = src_height_q;
    assign pyramid_done_out  = pyramid_done_q;
    assign start_dropped_out = start_dropped_q;

endmodule

// File: tb/tb_octave_scheduler.sv
// tb/tb_octave_scheduler.sv - randomized check of octave_scheduler against a pass-level reference model
module tb_octave_scheduler;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int N  = 3;
    localparam int AW = 13;
    localparam int TO = 100;

    logic          clk_100mhz;
    logic          rst;
    logic          start_in, resize_done_in, tx_req_in;
    logic          resize_start_out, rd_sel_out, tx_grant_out, busy_out;
    logic          pyramid_done_out, error_out, start_dropped_out;
    logic [AW-1:0] src_base_out, dst_base_out;
    logic [15:0]   src_width_out, src_height_out;
    logic [1:0]    pass_out;

    octave_scheduler #(
        .WIDTH(W), .HEIGHT(H), .NUM_OCTAVES(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in            (clk_100mhz),
        .rst_in            (rst),
        .start_in          (start_in),
        .resize_start_out  (resize_start_out),
        .resize_done_in    (resize_done_in),
        .src_base_out      (src_base_out),
        .dst_base_out      (dst_base_out),
        .src_width_out     (src_width_out),
        .src_height_out    (src_height_out),
        .pass_out          (pass_out),
        .rd_sel_out        (rd_sel_out),
        .tx_req_in         (tx_req_in),
        .tx_grant_out      (tx_grant_out),
        .busy_out          (busy_out),
        .pyramid_done_out  (pyramid_done_out),
        .error_out         (error_out),
        .start_dropped_out (start_dropped_out)
    );

    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: whether a pyramid build is running, which pass, and whether the pass just launched.
    bit m_cfg, m_run, m_launch, m_grant, m_drop, m_pdone, m_err;
    int m_pass, m_wcnt;
    int cd;
    int fixed_delay;
    bit no_resp;
    int dut_starts, dut_pdone;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_base(input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) s += (W >> i) * (H >> i);
        return s;
    endfunction

    task automatic model_reset();
        m_cfg = 0; m_run = 0; m_launch = 0; m_grant = 0; m_drop = 0;
        m_pdone = 0; m_err = 0; m_pass = 0; m_wcnt = 0; cd = 0;
    endtask

    task automatic compare_all();
        check_eq("resize_start", resize_start_out, m_launch);
        check_eq("busy", busy_out, m_run);
        check_eq("pass", pass_out, m_pass);
        check_eq("src_base", src_base_out, m_cfg ? ref_base(m_pass) : 0);
        check_eq("dst_base", dst_base_out, m_cfg ? ref_base(m_pass + 1) : 0);
        check_eq("src_width", src_width_out, m_cfg ? (W >> m_pass) : 0);
        check_eq("src_height", src_height_out, m_cfg ? (H >> m_pass) : 0);
        check_eq("tx_grant", tx_grant_out, m_grant);
        check_eq("rd_sel", rd_sel_out, m_grant);
        check_eq("pyramid_done", pyramid_done_out, m_pdone);
        check_eq("start_dropped", start_dropped_out, m_drop);
        check_eq("error", error_out, m_err);
    endtask

    task automatic tick(input bit s, input bit r, input bit extra_done);
        bit d, acc;
        @(negedge clk_100mhz);
        d = (cd == 1) || extra_done;
        if (cd > 0) cd--;
        start_in       = s;
        tx_req_in      = r;
        resize_done_in = d;
        @(posedge clk_100mhz);
        #1;
        acc     = s && !m_run && !m_grant;
        m_drop  = s && !acc;
        m_pdone = 0;
        if (!r) m_grant = 0;
        else if (!m_run && !acc) m_grant = 1;
        if (acc) begin
            m_cfg = 1; m_run = 1; m_pass = 0; m_launch = 1; m_err = 0;
        end else if (m_run && m_launch) begin
            m_launch = 0; m_wcnt = 0;
        end else if (m_run) begin
            if (d) begin
                if (m_pass == N - 2) begin
                    m_run = 0; m_pdone = 1;
                end else begin
                    m_pass++; m_launch = 1;
                end
            end
`ifdef OCTAVE_SCHED_TIMEOUT_EN
            else if (m_wcnt == TO - 1) begin
                m_run = 0; m_err = 1;
            end else begin
                m_wcnt++;
            end
`endif
        end
        if (m_launch) cd = no_resp ? 0 : (fixed_delay > 0 ? fixed_delay : int'($urandom_range(2, 60)));
        if (resize_start_out) dut_starts++;
        if (pyramid_done_out) dut_pdone++;
        compare_all();
    endtask

    initial begin
        bit r;
        rst = 1'b1;
        start_in = 0; resize_done_in = 0; tx_req_in = 0;
        model_reset();
        fixed_delay = 50; no_resp = 0;
        repeat (3) @(posedge clk_100mhz);
        #1;
        compare_all();
        @(negedge clk_100mhz);
        rst = 1'b0;

        // Two-pass build with a start during pass 1 and the sender waiting.
        dut_starts = 0; dut_pdone = 0;
        tick(1, 0, 0);
        check_eq("pass0_dst", dst_base_out, 4096);
        for (int i = 1; i < 130; i++) begin
            tick(i == 70, i >= 80, 0);
            if (i == 50) check_eq("pass1_dst", dst_base_out, 5120);
            if (i == 70) begin
                check_eq("drop_in_pass1", start_dropped_out, 1);
                check_eq("pass_held", pass_out, 1);
            end
            if (i == 100) begin
                check_eq("done_pulse", pyramid_done_out, 1);
                check_eq("no_grant_at_done", tx_grant_out, 0);
            end
            if (i == 101) check_eq("grant_after_done", tx_grant_out, 1);
        end
        check_eq("start_pulses", dut_starts, 2);
        check_eq("done_pulses", dut_pdone, 1);
        check_eq("idle_after", busy_out, 0);
        tick(0, 0, 0);
        check_eq("grant_drop", tx_grant_out, 0);
        tick(0, 1, 0);
        tick(1, 1, 0);
        check_eq("start_while_granted", start_dropped_out, 1);
        tick(0, 0, 0);
        tick(1, 1, 0);
        check_eq("start_beats_req", resize_start_out, 1);
        check_eq("start_beats_req_grant", tx_grant_out, 0);
        for (int i = 0; i < 120; i++) tick(0, 1, 0);
        check_eq("grant_after_second", tx_grant_out, 1);
        tick(0, 0, 0);

        // Asynchronous reset in the WAIT of pass 1.
        fixed_delay = 40;
        tick(1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0);
            if (m_run && !m_launch && m_pass == 1 && cd < 30) break;
        end
        check_eq("reached_pass1", pass_out, 1);
        check_eq("reached_pass1_busy", busy_out, 1);
        #2;
        start_in = 0; resize_done_in = 0; tx_req_in = 0;
        rst = 1'b1;
        #1;
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_pass", pass_out, 0);
        check_eq("rst_src", src_base_out, 0);
        check_eq("rst_dst", dst_base_out, 0);
        check_eq("rst_width", src_width_out, 0);
        check_eq("rst_start", resize_start_out, 0);
        model_reset();
        @(negedge clk_100mhz);
        rst = 1'b0;
        tick(1, 0, 0);
        check_eq("restart_pass", pass_out, 0);
        check_eq("restart_dst", dst_base_out, 4096);
        for (int i = 0; i < 100; i++) tick(0, 0, 0);

        // Randomized traffic.
        fixed_delay = 0;
        r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 20 == 0) r = !r;
            tick(($urandom % 25) == 0, r, ($urandom % 40) == 0);
        end

`ifdef OCTAVE_SCHED_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0);
            if (!m_run) break;
        end
        check_eq("idle_before_timeout", busy_out, 0);
        no_resp = 1;
        tick(1, 0, 0);
        for (int i = 0; i < 105; i++) tick(0, 0, 0);
        check_eq("timeout_error", error_out, 1);
        check_eq("timeout_busy", busy_out, 0);
        no_resp = 0;
        fixed_delay = 20;
        tick(1, 0, 0);
        check_eq("error_cleared", error_out, 0);
        for (int i = 0; i < 60; i++) tick(0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
